inst_mem: RTL and testbench
===========================

# inst_mem

Instruction memory that sits on the fetch side of the `cpu` core. It answers the core's `rom_ce_o`/`rom_addr_o` fetch requests with `rom_data_i`, so it is the responder for the core's instruction-fetch initiator. It also provides a byte-serial program-load port that fills the word array from a bench, UART bridge or boot controller through a small load state machine. Fetch is combinational because the core's `if_id` stage registers the returned word.

## Interface
- `ADDR_W`, default 10: word-address width; depth is 2^ADDR_W 32-bit words.
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst`  in  1  reset, asynchronous and active-low.
- `ce_i`  in  1  fetch enable; driven by the core's `rom_ce_o`.
- `addr_i`  in  32  fetch byte address; driven by the core's `rom_addr_o`.
- `inst_o`  out  32  fetched instruction; drives the core's `rom_data_i`.
- `misalign_o`  out  1  high when a fetch is requested with `addr_i[1:0] != 0`.
- `ld_start_i`  in  1  one-cycle pulse that starts a load at word 0.
- `ld_len_i`  in  ADDR_W+1  number of words to load; sampled when `ld_start_i` is accepted.
- `ld_byte_i`  in  8  load data byte.
- `ld_valid_i`  in  1  load byte valid.
- `ld_ready_o`  out  1  load byte ready.
- `ld_busy_o`  out  1  high while a load is in progress.
- `ld_done_o`  out  1  one-cycle pulse when a load completes.
- `cksum_o`  out  8  load checksum (see Configuration).

## Operation
- **Fetch** (combinational):
  - `inst_o` = mem[`addr_i[ADDR_W+1:2]`] when all of these hold: `ce_i` is high, state is not LOAD, `addr_i[1:0]` = 0, and `addr_i[31:ADDR_W+2]` = 0.
  - Otherwise `inst_o` = 32'h0 (NOP).
  - `misalign_o` = `ce_i` & (`addr_i[1:0]` != 0).
- **Load FSM** states: IDLE, LOAD, DONE.
  - IDLE: when `ld_start_i` is high, latch `ld_len_i`, clear the word counter, byte counter and checksum, then go to LOAD. If `ld_len_i` = 0, go straight to DONE instead.
  - LOAD: `ld_ready_o` = 1. A byte is accepted when `ld_valid_i` & `ld_ready_o` are both high.
    - Bytes are packed big-endian: the first byte accepted goes to bits [31:24].
    - When the 4th byte of a word is accepted, the assembled word is written to mem[word_cnt] and word_cnt increments.
    - When word_cnt reaches the latched length, go to DONE.
  - DONE: `ld_done_o` = 1 for exactly one cycle, then return to IDLE.
- `ld_start_i` is ignored in LOAD and DONE.
- `ld_busy_o` is high only in LOAD.
- The memory array has no reset. Words that are not loaded keep their previous contents.

## Timing
- Reset values:
  - FSM = IDLE.
  - `ld_ready_o`, `ld_busy_o`, `ld_done_o` = 0.
  - `cksum_o` = 0.
  - Byte counter, word counter and byte buffer = 0.
- Fetch latency is zero cycles: `inst_o` follows `addr_i` in the same cycle.
- Start to first ready: `ld_ready_o` rises in the cycle after `ld_start_i` is sampled.
- Write timing: the write to mem happens on the edge that accepts byte 4. The new word is visible to fetch on the following cycle, once the FSM has left LOAD.
- Completion: the `ld_done_o` pulse comes one cycle after the final write. Fetch is re-enabled in that DONE cycle.
- Throughput: one byte per cycle.
- Reset mid-load: the FSM returns to IDLE asynchronously and the partial-word buffer is discarded. Words already written stay in memory.

## Configuration
- `INST_MEM_CKSUM_EN`:
  - Defined: `cksum_o` = sum modulo 256 of every byte accepted since the last load start. It is cleared on start and holds its value after DONE.
  - Undefined: `cksum_o` is tied to 8'h0 and no adder is built.

## Structure
- The shared package (`defines.v`) holds the FSM state encodings, the NOP word constant, and reuses the `` `RegBus`` and `` `InstBus`` widths.
- The load byte assembler is a natural sub-module, `inst_mem_packer`. It shifts in 8-bit bytes and outputs a 32-bit word with a word-valid strobe.

## Test plan
- **Reset and empty fetch:** after reset, `ce_i`=1, `addr_i`=0 -> `ld_ready_o`=0, `ld_busy_o`=0 and `cksum_o`=0.
- **Two-word load:** `ld_len_i`=2, bytes 24 02 00 05 3C 01 12 34 -> `ld_done_o` pulses once. Fetch `addr_i`=0 returns 32'h24020005 and `addr_i`=4 returns 32'h3C011234. With `INST_MEM_CKSUM_EN` defined, `cksum_o`=8'hAE.
- **Fetch during load:** while in LOAD, `ce_i`=1, `addr_i`=0 -> `inst_o`=0. Also: `ld_valid_i` deasserted for 3 cycles mid-word -> the word is still assembled correctly.
- **Bad fetch addresses:** `addr_i`=32'h2 -> `misalign_o`=1 and `inst_o`=0. `addr_i`=32'h1000 with `ADDR_W`=10 -> `inst_o`=0. `ce_i`=0 -> `inst_o`=0.
- **Zero-length and ignored start:** `ld_len_i`=0 -> IDLE then DONE, one `ld_done_o` pulse and no write. `ld_start_i` pulsed during LOAD -> ignored.
- **Reset mid-load:** assert `rst` low after word 0 plus 2 bytes of word 1 -> FSM returns to IDLE, mem[0] is retained, and mem[1] is unchanged from its prior value.

Source files
------------

// File: rtl/inst_mem_pkg.sv
// inst_mem_pkg: shared widths, NOP word and load FSM encoding for inst_mem
package inst_mem_pkg;
  localparam int REG_BUS_W = 32;
  localparam int INST_BUS_W = 32;
  localparam logic [INST_BUS_W-1:0] NOP_INST = '0;
  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DONE} ld_state_e;
endpackage

// File: rtl/inst_mem_packer.sv
// inst_mem_packer: shifts load bytes in big-endian order and strobes each completed 32-bit word
//   clk, rst (async active-low), clr (restart word), en (byte accepted), byte_i
//   word_o (assembled word, valid with word_vld_o), word_vld_o (4th byte accepted this cycle)
module inst_mem_packer
  import inst_mem_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  en,
  input  logic [7:0]            byte_i,
  output logic [INST_BUS_W-1:0] word_o,
  output logic                  word_vld_o
);
  logic [1:0]  cnt;
  logic [23:0] buf_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt   <= '0;
      buf_q <= '0;
    end else if (clr) begin
      cnt   <= '0;
      buf_q <= '0;
    end else if (en) begin
      cnt   <= cnt + 2'd1;
      buf_q <= {buf_q[15:0], byte_i};
    end
  // the 4th byte is taken straight from the input so the write lands on its accepting edge
  assign word_o     = {buf_q, byte_i};
  assign word_vld_o = en & (cnt == 2'd3);
endmodule

// File: rtl/inst_mem.sv
// inst_mem: instruction ROM with combinational fetch and a byte-serial program-load port
//   fetch: ce_i, addr_i -> inst_o (NOP when disabled, loading, misaligned or out of range), misalign_o
//   load:  ld_start_i, ld_len_i, ld_byte_i, ld_valid_i -> ld_ready_o, ld_busy_o, ld_done_o
//   cksum_o: byte sum of the current/last load when INST_MEM_CKSUM_EN is defined, else 0
//   rst is asynchronous active-low
module inst_mem
  import inst_mem_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce_i,
  input  logic [REG_BUS_W-1:0]  addr_i,
  output logic [INST_BUS_W-1:0] inst_o,
  output logic                  misalign_o,
  input  logic                  ld_start_i,
  input  logic [ADDR_W:0]       ld_len_i,
  input  logic [7:0]            ld_byte_i,
  input  logic                  ld_valid_i,
  output logic                  ld_ready_o,
  output logic                  ld_busy_o,
  output logic                  ld_done_o,
  output logic [7:0]            cksum_o
);
  localparam logic [ADDR_W:0] ONE = 1;
  ld_state_e state, state_nxt;
  logic [ADDR_W:0] len_q, word_cnt;
  logic acc, clr, word_vld, fetch_ok;
  logic [INST_BUS_W-1:0] word;
  logic [INST_BUS_W-1:0] mem [2**ADDR_W];
  assign acc = ld_valid_i & ld_ready_o;
  assign clr = (state == ST_IDLE) & ld_start_i;
  inst_mem_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (clr),
    .en         (acc),
    .byte_i     (ld_byte_i),
    .word_o     (word),
    .word_vld_o (word_vld)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= ST_IDLE;
    else state <= state_nxt;
  always_comb
    state_nxt = (state == ST_IDLE) ? (ld_start_i ? ((ld_len_i == '0) ? ST_DONE : ST_LOAD) : ST_IDLE) :
                (state == ST_LOAD) ? ((word_vld && (word_cnt + ONE == len_q)) ? ST_DONE : ST_LOAD) :
                ST_IDLE;
  always_comb begin
    ld_ready_o = (state == ST_LOAD);
    ld_busy_o  = (state == ST_LOAD);
    ld_done_o  = (state == ST_DONE);
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      len_q    <= '0;
      word_cnt <= '0;
    end else if (clr) begin
      len_q    <= ld_len_i;
      word_cnt <= '0;
    end else if (word_vld) begin
      word_cnt <= word_cnt + ONE;
    end
  always_ff @(posedge clk)
    if (word_vld) mem[word_cnt[ADDR_W-1:0]] <= word;
  assign fetch_ok   = ce_i & (state != ST_LOAD) & (addr_i[1:0] == 2'b00) & ((addr_i >> (ADDR_W + 2)) == '0);
  assign inst_o     = fetch_ok ? mem[addr_i[ADDR_W+1:2]] : NOP_INST;
  assign misalign_o = ce_i & (addr_i[1:0] != 2'b00);
`ifdef INST_MEM_CKSUM_EN
  logic [7:0] cksum_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) cksum_q <= '0;
    else if (clr) cksum_q <= '0;
    else if (acc) cksum_q <= cksum_q + ld_byte_i;
  assign cksum_o = cksum_q;
`else
  assign cksum_o = 8'h0;
`endif
endmodule

// File: tb/tb_inst_mem.sv
// tb_inst_mem: randomized self-checking bench for inst_mem against a queue-based load model
module tb_inst_mem;
  localparam int AW = 10;
  logic        clk = 0, rst = 0, ce_i = 0, ld_start_i = 0, ld_valid_i = 0;
  logic [31:0] addr_i = 0;
  logic [AW:0] ld_len_i = 0;
  logic [7:0]  ld_byte_i = 0;
  logic [31:0] inst_o;
  logic        misalign_o, ld_ready_o, ld_busy_o, ld_done_o;
  logic [7:0]  cksum_o;
  always #5 clk = ~clk;
  inst_mem #(.ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .ce_i(ce_i), .addr_i(addr_i), .inst_o(inst_o), .misalign_o(misalign_o),
    .ld_start_i(ld_start_i), .ld_len_i(ld_len_i), .ld_byte_i(ld_byte_i), .ld_valid_i(ld_valid_i),
    .ld_ready_o(ld_ready_o), .ld_busy_o(ld_busy_o), .ld_done_o(ld_done_o), .cksum_o(cksum_o)
  );
  int errors = 0, checks = 0, done_cnt = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  // model: a load is "a queue of bytes grouped by four into consecutive words"
  bit          m_load = 0, m_done = 0;
  int          m_len = 0, m_words = 0;
  logic [7:0]  m_q[$];
  logic [7:0]  m_ck = 0;
  logic [31:0] m_mem [1 << AW];
  bit          m_known [1 << AW];
  always @(posedge clk or negedge rst)
    if (!rst) begin
      m_load = 0; m_done = 0; m_ck = 0; m_q.delete();
    end else if (m_done) begin
      m_done = 0;
    end else if (m_load) begin
      if (ld_valid_i) begin
        m_ck += ld_byte_i;
        m_q.push_back(ld_byte_i);
        if (m_q.size() == 4) begin
          m_mem[m_words] = {m_q[0], m_q[1], m_q[2], m_q[3]};
          m_known[m_words] = 1;
          m_q.delete();
          m_words++;
          if (m_words == m_len) begin m_load = 0; m_done = 1; end
        end
      end
    end else if (ld_start_i) begin
      m_len = int'(ld_len_i); m_words = 0; m_ck = 0; m_q.delete();
      if (m_len == 0) m_done = 1; else m_load = 1;
    end
  function automatic logic [7:0] exp_ck();
`ifdef INST_MEM_CKSUM_EN
    return m_ck;
`else
    return 8'h0;
`endif
  endfunction
  initial begin
    int  idx;
    bit  ok;
    forever begin
      @(negedge clk); #2;
      if (rst) begin
        if (ld_done_o) done_cnt++;
        chk("ready", ld_ready_o, m_load);
        chk("busy", ld_busy_o, m_load);
        chk("done", ld_done_o, m_done);
        chk("cksum", cksum_o, exp_ck());
        chk("misalign", misalign_o, ce_i && addr_i[1:0] != 0);
        idx = int'(addr_i[AW+1:2]);
        ok  = ce_i && !m_load && addr_i[1:0] == 0 && (addr_i >> (AW + 2)) == 0;
        if (!ok) chk("inst_nop", inst_o, 32'h0);
        else if (m_known[idx]) chk("inst", inst_o, m_mem[idx]);
      end
    end
  end
  logic [7:0] bq[$];
  task automatic load(input int len, input int gap_pct, input int hold_at, input bit poke);
    int i = 0, holds = 0, d0 = done_cnt;
    @(negedge clk); ld_start_i = 1; ld_len_i = (AW+1)'(len);
    @(negedge clk); ld_start_i = 0;
    while (i < bq.size()) begin
      if (i == hold_at && holds < 3) begin
        ld_valid_i = 0; ld_byte_i = 8'($urandom); holds++;
      end else if (int'($urandom_range(99)) < gap_pct) begin
        ld_valid_i = 0; ld_byte_i = 8'($urandom);
        if (poke) begin ld_start_i = 1; ld_len_i = 0; end
      end else begin
        ld_valid_i = 1; ld_byte_i = bq[i]; i++;
      end
      @(negedge clk); ld_start_i = 0;
    end
    ld_valid_i = 0;
    repeat (3) @(negedge clk);
    chk("done_pulses", done_cnt - d0, 1);
  endtask
  task automatic fetch(input logic c, input logic [31:0] a, input logic [31:0] exp, input string nm);
    @(negedge clk); ce_i = c; addr_i = a; #2;
    chk(nm, inst_o, exp);
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    logic [31:0] prior_w1;
    ce_i = 1; addr_i = 0;
    repeat (2) @(negedge clk);
    #2;
    chk("rst_ready", ld_ready_o, 0);
    chk("rst_busy", ld_busy_o, 0);
    chk("rst_done", ld_done_o, 0);
    chk("rst_cksum", cksum_o, 0);
    @(negedge clk); rst = 1;
    #2;
    chk("post_rst_ready", ld_ready_o, 0);
    chk("post_rst_cksum", cksum_o, 0);
    // two-word load with a 3-cycle valid hold mid-word; fetch at address 0 stays NOP while loading
    bq = '{8'h24, 8'h02, 8'h00, 8'h05, 8'h3C, 8'h01, 8'h12, 8'h34};
    ce_i = 1; addr_i = 0;
    load(2, 20, 2, 0);
    fetch(1, 32'h0, 32'h24020005, "w0");
    fetch(1, 32'h4, 32'h3C011234, "w1");
`ifdef INST_MEM_CKSUM_EN
    chk("cksum_two_word", cksum_o, 8'hAE);
`endif
    // bad fetches
    fetch(1, 32'h2, 32'h0, "misaligned_nop");
    chk("misalign_set", misalign_o, 1);
    fetch(1, 32'h1000, 32'h0, "out_of_range_nop");
    fetch(0, 32'h0, 32'h0, "ce_low_nop");
    chk("misalign_ce_low", misalign_o, 0);
    // zero-length load writes nothing
    bq.delete();
    load(0, 0, -1, 0);
    fetch(1, 32'h0, 32'h24020005, "zero_len_keep");
    // start pulses during LOAD are ignored
    bq.delete();
    for (int k = 0; k < 12; k++) bq.push_back(8'($urandom));
    load(3, 40, -1, 1);
    fetch(1, 32'h8, {bq[8], bq[9], bq[10], bq[11]}, "w2_after_poke");
    // reset after word 0 plus two bytes of word 1
    prior_w1 = m_mem[1];
    @(negedge clk); ld_start_i = 1; ld_len_i = 2;
    @(negedge clk); ld_start_i = 0;
    for (int k = 0; k < 6; k++) begin
      ld_valid_i = 1; ld_byte_i = 8'(8'h10 + k);
      @(negedge clk);
    end
    ld_valid_i = 0; rst = 0; #2;
    chk("midrst_busy", ld_busy_o, 0);
    chk("midrst_ready", ld_ready_o, 0);
    chk("midrst_cksum", cksum_o, 0);
    @(negedge clk); rst = 1;
    fetch(1, 32'h0, 32'h10111213, "midrst_w0");
    fetch(1, 32'h4, prior_w1, "midrst_w1");
    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    load(1, 0, -1, 0);
    fetch(1, 32'h0, 32'hAABBCCDD, "buffer_discarded");
    // randomized loads and fetches
    for (int r = 0; r < 6; r++) begin
      int n = int'($urandom_range(1, 6));
      bq.delete();
      for (int k = 0; k < 4 * n; k++) bq.push_back(8'($urandom));
      ce_i = 1'($urandom); addr_i = 32'($urandom_range(0, 7)) << 2;
      load(n, int'($urandom_range(0, 50)), -1, 1'($urandom));
      for (int f = 0; f < 20; f++) begin
        int sel = int'($urandom_range(9));
        @(negedge clk);
        ce_i = ($urandom_range(4) != 0);
        addr_i = (sel == 0) ? 32'($urandom) :
                 (sel == 1) ? (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(1, 3)) :
                 (sel == 2) ? 32'h1000 + (32'($urandom_range(0, 255)) << 2) :
                 (32'($urandom_range(0, 7)) << 2);
      end
    end
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
